// File: rtl/parking_spot_allocator.sv
// Eight-spot parking lot controller: edge-detects gate requests, allocates the
// lowest free spot, releases spots on exit and holds a gate open for GateCycles.
module parking_spot_allocator #(
  parameter int unsigned GateCycles = 50000000,
  parameter int unsigned TimerWidth = 26
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       EntryReq,
  input  logic       ExitReq,
  input  logic [2:0] ExitSpot,
  output logic [7:0] SpotsControl,
  output logic [3:0] FreeCount,
  output logic       Full,
  output logic       EntryGate,
  output logic       ExitGate,
  output logic [2:0] AssignedSpot,
  output logic       AssignValid,
  output logic       EntryDenied,
  output logic       ExitError
);

  typedef enum logic [1:0] {IDLE, ENTRY_GATE, EXIT_GATE} state_t;

  localparam logic [TimerWidth-1:0] TimerLoad = TimerWidth'(GateCycles - 1);

  state_t                state, state_next;
  logic                  entry_prev, exit_prev;
  logic                  entry_pend, exit_pend, entry_pend_next, exit_pend_next;
  logic [2:0]            exit_spot_q, exit_spot_next;
  logic [TimerWidth-1:0] timer, timer_next;
  logic [7:0]            spots_next;
  logic                  entry_gate_next, exit_gate_next;
  logic [2:0]            assigned_next;
  logic                  valid_next, denied_next, error_next;
  logic                  entry_srv, exit_srv;
  logic                  free_found;
  logic [2:0]            free_idx;

  assign Full      = &SpotsControl;
  assign FreeCount = 4'(8 - $countones(SpotsControl));

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (!free_found && !SpotsControl[i]) begin
        free_found = 1'b1;
        free_idx   = 3'(i);
      end
    end
  end

  always_comb begin
    state_next      = state;
    spots_next      = SpotsControl;
    entry_gate_next = EntryGate;
    exit_gate_next  = ExitGate;
    timer_next      = timer;
    assigned_next   = AssignedSpot;
    valid_next      = 1'b0;
    denied_next     = 1'b0;
    error_next      = 1'b0;
    entry_srv       = 1'b0;
    exit_srv        = 1'b0;

    case (state)
      IDLE: begin
        if (exit_pend) begin
          exit_srv = 1'b1;
          if (SpotsControl[exit_spot_q]) begin
            spots_next[exit_spot_q] = 1'b0;
            exit_gate_next          = 1'b1;
            timer_next              = TimerLoad;
            state_next              = EXIT_GATE;
          end else begin
            error_next = 1'b1;
          end
        end else if (entry_pend) begin
          entry_srv = 1'b1;
          if (Full) begin
            denied_next = 1'b1;
          end else begin
            spots_next[free_idx] = 1'b1;
            assigned_next        = free_idx;
            valid_next           = 1'b1;
            entry_gate_next      = 1'b1;
            timer_next           = TimerLoad;
            state_next           = ENTRY_GATE;
          end
        end
      end
      ENTRY_GATE, EXIT_GATE: begin
        if (timer == '0) begin
          entry_gate_next = 1'b0;
          exit_gate_next  = 1'b0;
          state_next      = IDLE;
        end else begin
          timer_next = timer - TimerWidth'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A new edge is dropped while its pending flag is already set.
  always_comb begin
    entry_pend_next = entry_pend ? ~entry_srv : (EntryReq & ~entry_prev);
    exit_pend_next  = exit_pend  ? ~exit_srv  : (ExitReq  & ~exit_prev);
    exit_spot_next  = (!exit_pend && ExitReq && !exit_prev) ? ExitSpot : exit_spot_q;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      SpotsControl <= '0;
      EntryGate    <= 1'b0;
      ExitGate     <= 1'b0;
      AssignedSpot <= '0;
      AssignValid  <= 1'b0;
      EntryDenied  <= 1'b0;
      ExitError    <= 1'b0;
      entry_prev   <= 1'b0;
      exit_prev    <= 1'b0;
      entry_pend   <= 1'b0;
      exit_pend    <= 1'b0;
      exit_spot_q  <= '0;
      timer        <= '0;
    end else begin
      state        <= state_next;
      SpotsControl <= spots_next;
      EntryGate    <= entry_gate_next;
      ExitGate     <= exit_gate_next;
      AssignedSpot <= assigned_next;
      AssignValid  <= valid_next;
      EntryDenied  <= denied_next;
      ExitError    <= error_next;
      entry_prev   <= EntryReq;
      exit_prev    <= ExitReq;
      entry_pend   <= entry_pend_next;
      exit_pend    <= exit_pend_next;
      exit_spot_q  <= exit_spot_next;
      timer        <= timer_next;
    end
  end

endmodule

// File: tb/tb_parking_spot_allocator.sv
// Self-checking bench: directed vector table, corner-case sequences and a
// randomized run against a behavioural lot model.
module tb_parking_spot_allocator;

  localparam int GATE = 4;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       EntryReq = 1'b0;
  logic       ExitReq = 1'b0;
  logic [2:0] ExitSpot = '0;
  logic [7:0] SpotsControl;
  logic [3:0] FreeCount;
  logic       Full, EntryGate, ExitGate, AssignValid, EntryDenied, ExitError;
  logic [2:0] AssignedSpot;

  parking_spot_allocator #(.GateCycles(GATE), .TimerWidth(4)) dut (
    .Clk(Clk), .Reset(Reset), .EntryReq(EntryReq), .ExitReq(ExitReq),
    .ExitSpot(ExitSpot), .SpotsControl(SpotsControl), .FreeCount(FreeCount),
    .Full(Full), .EntryGate(EntryGate), .ExitGate(ExitGate),
    .AssignedSpot(AssignedSpot), .AssignValid(AssignValid),
    .EntryDenied(EntryDenied), .ExitError(ExitError)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Behavioural model of the lot: occupancy array plus a count of gate cycles left.
  bit       m_occ[8];
  int       m_left;
  bit       m_eg, m_xg, m_av, m_den, m_err;
  int       m_as;
  bit       m_epend, m_xpend, m_eprev, m_xprev;
  int       m_xspot;

  task automatic model_reset();
    foreach (m_occ[i]) m_occ[i] = 0;
    m_left = 0; m_eg = 0; m_xg = 0; m_av = 0; m_den = 0; m_err = 0; m_as = 0;
    m_epend = 0; m_xpend = 0; m_eprev = 0; m_xprev = 0; m_xspot = 0;
  endtask

  function automatic int model_free();
    int c = 0;
    foreach (m_occ[i]) if (!m_occ[i]) c++;
    return c;
  endfunction

  function automatic int model_vec();
    int v = 0;
    foreach (m_occ[i]) if (m_occ[i]) v += (1 << i);
    return v;
  endfunction

  task automatic model_step(input bit e, input bit x, input int s);
    bit e_srv = 0, x_srv = 0;
    bit e_edge = e && !m_eprev;
    bit x_edge = x && !m_xprev;
    m_av = 0; m_den = 0; m_err = 0;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin m_eg = 0; m_xg = 0; end
    end else if (m_xpend) begin
      x_srv = 1;
      if (m_occ[m_xspot]) begin
        m_occ[m_xspot] = 0; m_xg = 1; m_left = GATE;
      end else m_err = 1;
    end else if (m_epend) begin
      e_srv = 1;
      if (model_free() == 0) m_den = 1;
      else begin
        for (int n = 0; n < 8; n++) begin
          if (!m_occ[n]) begin m_occ[n] = 1; m_as = n; break; end
        end
        m_av = 1; m_eg = 1; m_left = GATE;
      end
    end
    if (m_xpend) m_xpend = !x_srv;
    else if (x_edge) begin m_xpend = 1; m_xspot = s; end
    if (m_epend) m_epend = !e_srv;
    else if (e_edge) m_epend = 1;
    m_eprev = e; m_xprev = x;
  endtask

  task automatic apply_reset();
    EntryReq = 0; ExitReq = 0; ExitSpot = '0;
    Reset = 1;
    tick();
    Reset = 0;
    model_reset();
  endtask

  task automatic wait_close();
    for (int n = 0; n < 20; n++) begin
      if (!EntryGate && !ExitGate) break;
      tick();
    end
    chk("gate_close", int'(EntryGate | ExitGate), 0);
  endtask

  task automatic do_entry();
    EntryReq = 1; tick();
    EntryReq = 0; tick();
  endtask

  typedef struct {
    logic e, x; logic [2:0] s;
    logic [7:0] spots; logic eg, xg, av; logic [2:0] as; logic den, err;
  } vec_t;

  vec_t vt[21];

  initial begin
    int cnt;
    bit re, rx;

    vt[0]  = '{1,0,0, 8'h00,0,0,0,0,0,0};
    vt[1]  = '{1,0,0, 8'h01,1,0,1,0,0,0};
    vt[2]  = '{0,0,0, 8'h01,1,0,0,0,0,0};
    vt[3]  = '{0,0,0, 8'h01,1,0,0,0,0,0};
    vt[4]  = '{0,0,0, 8'h01,1,0,0,0,0,0};
    vt[5]  = '{0,0,0, 8'h01,0,0,0,0,0,0};
    vt[6]  = '{0,1,5, 8'h01,0,0,0,0,0,0};
    vt[7]  = '{0,1,5, 8'h01,0,0,0,0,0,1};
    vt[8]  = '{0,0,0, 8'h01,0,0,0,0,0,0};
    vt[9]  = '{1,1,0, 8'h01,0,0,0,0,0,0};
    vt[10] = '{1,0,0, 8'h00,0,1,0,0,0,0};
    vt[11] = '{1,0,0, 8'h00,0,1,0,0,0,0};
    vt[12] = '{1,0,0, 8'h00,0,1,0,0,0,0};
    vt[13] = '{1,0,0, 8'h00,0,1,0,0,0,0};
    vt[14] = '{1,0,0, 8'h00,0,0,0,0,0,0};
    vt[15] = '{1,0,0, 8'h01,1,0,1,0,0,0};
    vt[16] = '{1,0,0, 8'h01,1,0,0,0,0,0};
    vt[17] = '{1,0,0, 8'h01,1,0,0,0,0,0};
    vt[18] = '{1,0,0, 8'h01,1,0,0,0,0,0};
    vt[19] = '{1,0,0, 8'h01,0,0,0,0,0,0};
    vt[20] = '{1,0,0, 8'h01,0,0,0,0,0,0};

    apply_reset();
    chk("rst_spots", SpotsControl, 0);
    chk("rst_free", FreeCount, 8);
    chk("rst_full", Full, 0);
    chk("rst_gates", {EntryGate, ExitGate}, 0);
    chk("rst_assign", {AssignValid, AssignedSpot}, 0);
    chk("rst_pulses", {EntryDenied, ExitError}, 0);

    for (int i = 0; i < 21; i++) begin
      EntryReq = vt[i].e; ExitReq = vt[i].x; ExitSpot = vt[i].s;
      tick();
      chk($sformatf("vec%0d_spots", i), SpotsControl, vt[i].spots);
      chk($sformatf("vec%0d_free", i), FreeCount, 8 - $countones(vt[i].spots));
      chk($sformatf("vec%0d_egate", i), EntryGate, vt[i].eg);
      chk($sformatf("vec%0d_xgate", i), ExitGate, vt[i].xg);
      chk($sformatf("vec%0d_valid", i), AssignValid, vt[i].av);
      chk($sformatf("vec%0d_spot", i), AssignedSpot, vt[i].as);
      chk($sformatf("vec%0d_denied", i), EntryDenied, vt[i].den);
      chk($sformatf("vec%0d_exterr", i), ExitError, vt[i].err);
    end

    // Fill the lot, then a ninth entry is denied.
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      do_entry();
      chk($sformatf("fill%0d_spot", k), AssignedSpot, k);
      chk($sformatf("fill%0d_valid", k), AssignValid, 1);
      wait_close();
    end
    chk("full_spots", SpotsControl, 8'hFF);
    chk("full_flag", Full, 1);
    chk("full_free", FreeCount, 0);
    do_entry();
    chk("deny_pulse", EntryDenied, 1);
    chk("deny_gate", EntryGate, 0);
    chk("deny_spots", SpotsControl, 8'hFF);
    tick();
    chk("deny_pulse_end", EntryDenied, 0);

    // Release spot 3 from a full lot, then re-grant it.
    ExitSpot = 3; ExitReq = 1; tick();
    ExitReq = 0; tick();
    chk("exit3_spots", SpotsControl, 8'hF7);
    cnt = 0;
    for (int n = 0; n < 20 && ExitGate; n++) begin cnt++; tick(); end
    chk("exit3_gate_len", cnt, GATE);
    chk("exit3_egate", EntryGate, 0);
    do_entry();
    chk("regrant_spot", AssignedSpot, 3);
    chk("regrant_spots", SpotsControl, 8'hFF);
    wait_close();

    // Asynchronous reset while the entry gate is open.
    apply_reset();
    do_entry(); wait_close();
    do_entry(); wait_close();
    do_entry();
    chk("pre_rst_spots", SpotsControl, 8'h07);
    chk("pre_rst_gate", EntryGate, 1);
    #1 Reset = 1;
    #1;
    chk("async_rst_gate", EntryGate, 0);
    chk("async_rst_spots", SpotsControl, 0);
    tick();
    Reset = 0;
    tick(); tick();
    chk("post_rst_spots", SpotsControl, 0);

    // Randomized run against the model.
    apply_reset();
    re = 0; rx = 0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(3) == 0) re = !re;
      if ($urandom_range(5) == 0) rx = !rx;
      EntryReq = re; ExitReq = rx; ExitSpot = 3'($urandom_range(7));
      @(posedge Clk);
      model_step(re, rx, int'(ExitSpot));
      #1;
      chk("rnd_spots", SpotsControl, model_vec());
      chk("rnd_free", FreeCount, model_free());
      chk("rnd_full", Full, int'(model_free() == 0));
      chk("rnd_gates", {EntryGate, ExitGate}, {m_eg, m_xg});
      chk("rnd_valid", AssignValid, m_av);
      chk("rnd_spot", AssignedSpot, m_as);
      chk("rnd_pulses", {EntryDenied, ExitError}, {m_den, m_err});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/parking_spot_allocator.md
Name: parking_spot_allocator

Overview:
Central controller for the 8-spot parking lot. Accepts entry and exit requests from the gate buttons, allocates the lowest-numbered free spot, and releases spots on exit. Drives the entry/exit gate outputs for a fixed open time. Publishes the 8-bit occupancy vector consumed by the LED matrix driver as SpotsControl (bit n = 1 means spot n is occupied).

Parameters:
GateCycles, 50000000, number of Clk cycles a gate stays open per grant (1 s at 50 MHz); must be >= 1
TimerWidth, 26, width of the gate countdown register; must hold GateCycles-1

Ports:
Clk  input  1  system clock; all state on rising edge
Reset  input  1  asynchronous, active-high reset
EntryReq  input  1  entry request level, synchronous to Clk; an event is a 0->1 transition
ExitReq  input  1  exit request level, synchronous to Clk; an event is a 0->1 transition
ExitSpot  input  3  spot being vacated; sampled in the ExitReq rising-edge cycle
SpotsControl  output  8  occupancy vector, registered
FreeCount  output  4  number of free spots, 0..8 (8 - popcount(SpotsControl)), combinational from SpotsControl
Full  output  1  high when SpotsControl == 8'hFF
EntryGate  output  1  entry gate open, registered
ExitGate  output  1  exit gate open, registered
AssignedSpot  output  3  spot granted by the last successful entry; holds its value between grants
AssignValid  output  1  one-cycle pulse when AssignedSpot is updated
EntryDenied  output  1  one-cycle pulse: entry serviced while the lot is full
ExitError  output  1  one-cycle pulse: exit named a spot that is not occupied

Behaviour:
- Reset, asynchronous: clears SpotsControl, EntryGate, ExitGate, AssignedSpot, AssignValid, EntryDenied, ExitError, the edge-detect registers, the pending flags and the timer. The state machine returns to IDLE. Reset during an open gate closes the gate immediately.
- Edge detect: a previous-value register is kept per request input.
  - A rising edge sets EntryPend, or sets ExitPend and latches ExitSpot.
  - An edge arriving while the same pending flag is already set is dropped.
  - Requests are captured in every state, including while a gate is open.
- States: IDLE, ENTRY_GATE, EXIT_GATE.
- IDLE, evaluated each cycle. Exit has priority over entry. Only one request is serviced per cycle.
  - ExitPend set, latched spot occupied: clear that bit, set ExitGate, load the timer with GateCycles-1, clear ExitPend, go to EXIT_GATE.
  - ExitPend set, latched spot free: pulse ExitError, clear ExitPend, stay in IDLE. No gate opens.
  - Else EntryPend set, Full: pulse EntryDenied, clear EntryPend, stay in IDLE.
  - Else EntryPend set, not Full: select the lowest index n with SpotsControl[n] == 0, then:
    - set bit n;
    - AssignedSpot <= n and pulse AssignValid;
    - set EntryGate and load the timer with GateCycles-1;
    - clear EntryPend, go to ENTRY_GATE.
- Latency: a request edge at cycle t is visible in pending at t+1. When IDLE and uncontended, the outputs update at t+2.
- ENTRY_GATE / EXIT_GATE:
  - The timer decrements each cycle.
  - In the cycle the timer is 0, the gate output is cleared and the state returns to IDLE.
  - The gate is high for exactly GateCycles cycles.
  - Pending requests are serviced in the first cycle back in IDLE.
- SpotsControl changes only on a grant or release, the same cycle the gate opens.
- The two gates are never high simultaneously.
- Simultaneous entry and exit edges: both are latched; exit is serviced first, entry after the exit gate closes.

Test Plan:
- Reset, then GateCycles=4, pulse EntryReq -> AssignedSpot=0, AssignValid one cycle, SpotsControl=8'h01, EntryGate high exactly 4 cycles, FreeCount=7.
- 8 sequential entries, then a 9th -> SpotsControl=8'hFF, Full=1, FreeCount=0; the 9th yields an EntryDenied pulse, EntryGate stays low, SpotsControl unchanged.
- Starting from 8'hFF, exit ExitSpot=3, then one entry -> SpotsControl 8'hF7 with ExitGate high 4 cycles; the entry is granted AssignedSpot=3 and SpotsControl returns to 8'hFF.
- Exit for ExitSpot=5 when SpotsControl=8'h01 -> ExitError pulse, no gate, SpotsControl unchanged.
- EntryReq and ExitReq (spot 0, occupied) rising in the same cycle -> ExitGate opens first; after it closes, EntryGate opens with AssignedSpot=0.
- Assert Reset while EntryGate is high with SpotsControl=8'h07 -> EntryGate=0 and SpotsControl=0 immediately, before the next clock edge. A held-high EntryReq does not re-trigger until it drops and rises again.
